// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit (master) and the data memory (slave).
interface mem_access_unit_if #(
    parameter int N = 32
);
    logic         dmem_req_o;
    logic         dmem_we_o;
    logic [N-1:0] dmem_addr_o;
    logic [N-1:0] dmem_wdata_o;
    logic         dmem_ack_i;
    logic [N-1:0] dmem_rdata_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
        input  dmem_ack_i, dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
        output dmem_ack_i, dmem_rdata_i
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: req/ack bus transaction, pipeline stall, load return, error flag.
// Optional build macro MEM_ALIGN_CHECK_EN rejects word-misaligned accesses without touching the bus.
module mem_access_unit #(
    parameter int N       = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_read_i,
    input  logic                 mem_write_i,
    input  logic [N-1:0]         addr_i,
    input  logic [N-1:0]         wdata_i,
    mem_access_unit_if.master    dmem,
    output logic                 stall_o,
    output logic [N-1:0]         load_data_o,
    output logic                 load_valid_o,
    output logic                 err_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t       r_state;
    logic [7:0]   r_cnt;
    logic         r_req;
    logic         r_we;
    logic [N-1:0] r_addr;
    logic [N-1:0] r_wdata;
    logic [N-1:0] r_load_data;
    logic         r_load_valid;
    logic         r_err;

    logic         w_access;
    logic         w_illegal;
    logic         w_misalign;

    assign w_access  = mem_read_i | mem_write_i;
    assign w_illegal = mem_read_i & mem_write_i;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = w_access & (addr_i[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // Reset gating keeps stall low while held in reset even if EX/MEM still shows an access.
    assign stall_o = reset & (((r_state == S_IDLE) & w_access) | (r_state == S_REQ));

    assign dmem.dmem_req_o   = r_req;
    assign dmem.dmem_we_o    = r_we;
    assign dmem.dmem_addr_o  = r_addr;
    assign dmem.dmem_wdata_o = r_wdata;
    assign load_data_o       = r_load_data;
    assign load_valid_o      = r_load_valid;
    assign err_o             = r_err;

    // State advances on the falling edge, in step with the pipeline registers.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 8'd0;
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_load_data  <= '0;
            r_load_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_load_valid <= 1'b0;
            r_err        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_illegal) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_misalign) begin
                        r_err   <= 1'b1;
                        if (mem_read_i) r_load_data <= '0;
                        r_state <= S_DONE;
                    end else if (w_access) begin
                        r_addr  <= addr_i;
                        r_wdata <= wdata_i;
                        r_we    <= mem_write_i;
                        r_req   <= 1'b1;
                        r_cnt   <= 8'd0;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    // An ack in the final wait cycle still wins over the timeout.
                    if (dmem.dmem_ack_i) begin
                        r_req <= 1'b0;
                        r_cnt <= 8'd0;
                        if (!r_we) begin
                            r_load_data  <= dmem.dmem_rdata_i;
                            r_load_valid <= 1'b1;
                        end
                        r_state <= S_DONE;
                    end else if (r_cnt == TO_LAST) begin
                        r_req       <= 1'b0;
                        r_cnt       <= 8'd0;
                        r_err       <= 1'b1;
                        r_load_data <= '0;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
